// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned N x N shift-add multiplier. A 2N-wide left shifter scales the
// multiplicand by the current bit index, and the result is accumulated into a 2N-bit product.

module left_shifter #(
    parameter int W  = 64,
    parameter int SW = $clog2(W)
) (
    input  logic [W-1:0]  data,
    input  logic [SW-1:0] shamt,
    output logic [W-1:0]  result
);
    assign result = data << shamt;
endmodule

// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
// in_ready is high only in IDLE. out_valid is high only in DONE, and product holds stable there
// until out_ready. Changes to a, b or in_valid outside IDLE have no effect.
module shift_add_multiplier #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product,
    output logic [1:0]       state_dbg
);
    localparam int PW = 2 * N;
    localparam int SW = $clog2(PW);
    localparam int CW = $clog2(N);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] acc;
    logic [PW-1:0] a_reg;
    logic [N-1:0]  b_reg;
    logic [CW-1:0] count;
    logic [PW-1:0] shifted;
    logic [SW-1:0] shamt;
    logic          last_step;

    assign shamt = SW'(count);

    left_shifter #(.W(PW), .SW(SW)) u_shifter (
        .data   (a_reg),
        .shamt  (shamt),
        .result (shifted)
    );

    // Stop once no set bits remain above the current one, or when the top bit is reached.
    assign last_step = ((b_reg >> 1) == '0) || (count == CW'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            acc   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= {{N{1'b0}}, a};
                        b_reg <= b;
                        acc   <= '0;
                        count <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (b_reg[0]) begin
                        acc <= acc + shifted;
                    end
                    b_reg <= b_reg >> 1;
                    count <= count + 1'b1;
                    if (last_step) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign product   = acc;
    assign state_dbg = state;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: a vector table of operands with their products and
// latencies, plus hand-written sequences for stall, mid-operation reset and back-to-back accepts.

module tb_shift_add_multiplier;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic [1:0]  state_dbg;

    int tests;
    int failed;
    int accept_cnt;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    shift_add_multiplier #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in_valid and in_ready are stable at the falling edge, so this predicts the next accept
    always @(negedge clk) begin
        if (rst && in_valid && in_ready) accept_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present operands, let one edge accept them, then drop in_valid.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("accept_in_ready_low", {63'd0, in_ready}, 64'd0);
    endtask

    // Count edges after the accept edge until out_valid rises, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) check("done_timeout", {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        int lat;
        logic [63:0] held;

        vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, 3};
        vecs[1] = '{32'h0000_1234,  32'd0,          64'h0,                   1};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 32};
        vecs[3] = '{32'd0,          32'h0000_0010,  64'h0,                   5};
        vecs[4] = '{32'hDEAD_BEEF,  32'd1,          64'h0000_0000_DEAD_BEEF, 1};
        vecs[5] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 32};
        vecs[6] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE, 2};
        vecs[7] = '{32'd100,        32'd1000,       64'd100000,              10};

        tests      = 0;
        failed     = 0;
        accept_cnt = 0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = '0;
        b          = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_product", product, 64'd0);
        check("reset_state", {62'd0, state_dbg}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // table-driven vectors, consumer always ready
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_product", i), product, vecs[i].p);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_back_to_idle", i), {63'd0, in_ready}, 64'd1);
            check($sformatf("vec%0d_valid_dropped", i), {63'd0, out_valid}, 64'd0);
        end

        // stalled consumer: result holds, new operands are ignored
        out_ready = 1'b0;
        start_op(32'd7, 32'h8000_0000);
        wait_done(lat);
        check("stall_latency", 64'(lat), 64'd32);
        check("stall_product", product, 64'h0000_0003_8000_0000);
        held = product;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 32'd1 + 32'(i);
            b        = 32'd1;
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("stall%0d_product", i), product, 64'h0000_0003_8000_0000);
            check($sformatf("stall%0d_in_ready", i), {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_valid", {63'd0, out_valid}, 64'd0);
        check("stall_release_ready", {63'd0, in_ready}, 64'd1);
        check("stall_product_kept", product, held);
        @(posedge clk);
        #1;
        check("stall_no_ghost_accept", {63'd0, in_ready}, 64'd1);

        // asynchronous reset in the middle of BUSY
        start_op(32'd9, 32'h0000_00FF);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_product", product, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        start_op(32'd2, 32'd2);
        wait_done(lat);
        check("postrst_latency", 64'(lat), 64'd2);
        check("postrst_product", product, 64'd4);
        @(posedge clk);
        #1;

        // back-to-back with in_valid held high; operands change right after each accept
        accept_cnt = 0;
        @(negedge clk);
        a        = 32'd5;
        b        = 32'd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 32'd11;
        b = 32'd13;
        check("b2b_first_accept", {63'd0, in_ready}, 64'd0);
        wait_done(lat);
        check("b2b_first_latency", 64'(lat), 64'd3);
        check("b2b_first_product", product, 64'd30);
        @(posedge clk);
        #1;
        check("b2b_idle_gap", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_second_accept", {63'd0, in_ready}, 64'd0);
        wait_done(lat);
        check("b2b_second_latency", 64'(lat), 64'd4);
        check("b2b_second_product", product, 64'd143);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_accept_count", 64'(accept_cnt), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Multi-cycle unsigned N×N multiplier sitting directly downstream of the combinational left-logical shifter.
- Each BUSY cycle it feeds the shifter the registered multiplicand and the bit index as shift amount, and conditionally adds the shifted value into a 2N-bit accumulator.
- Uses valid/ready handshakes on both sides. Serves as the ALU's MUL/MULHU execution unit.

Parameters:
- N, 32, operand width; product is 2N bits; internal shifter instance is 2N wide with shamt width $clog2(2N).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  N  multiplicand, unsigned.
- b  input  N  multiplier, unsigned.
- out_valid  output  1  product valid; high only in DONE.
- out_ready  input  1  consumer accepts product.
- product  output  2N  registered accumulator, a*b when out_valid.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, accumulator=0, a_reg=0, b_reg=0, count=0, product=0, out_valid=0, in_ready=1 (combinational from state).
- States: IDLE, BUSY, DONE. Transitions are taken only on rising clk edges.
- IDLE:
  - On in_valid && in_ready: a_reg={N'b0,a}, b_reg=b, accumulator=0, count=0, go to BUSY.
  - in_valid low: stay in IDLE.
- BUSY (in_ready=0, out_valid=0):
  - Each cycle, if b_reg[0]: accumulator += shifter(a_reg, count), 2N-bit add, carry-out discarded (it cannot occur).
  - b_reg <= b_reg >> 1; count <= count+1.
  - Go to DONE when (b_reg>>1)==0 or count==N-1; otherwise stay in BUSY.
- Latency: accept edge k → out_valid high after edge k+L.
  - L=1 if b==0.
  - Otherwise L=floor(log2 b)+1.
  - Max L=N.
- DONE (out_valid=1):
  - product and out_valid hold stable while out_ready=0.
  - On out_ready: go to IDLE and drop out_valid.
  - No new operand is accepted in the same cycle; next accept is the earliest edge after return to IDLE.
- in_valid during BUSY/DONE is ignored; a, b and in_valid changes have no effect.
- product is a direct register output. It keeps its last value in IDLE and is only meaningful when out_valid=1.
- Reset mid-operation (any state) aborts immediately to reset values; no partial product is ever presented.
- Arithmetic is purely unsigned. a=0 still takes L cycles per b. Full product width: no truncation.

Test Plan:
- Reset then a=3, b=5 pulse in_valid, out_ready=1 → in_ready low after accept edge; out_valid after exactly 3 BUSY cycles; product=0x0000_0000_0000_000F; in_ready high next cycle.
- a=0x1234, b=0 → L=1; product=0; out_valid one cycle after BUSY entry.
- a=0xFFFF_FFFF, b=0xFFFF_FFFF → L=32; product=0xFFFF_FFFE_0000_0001.
- a=7, b=0x8000_0000 with out_ready=0 for 5 cycles → product=0x0000_0003_8000_0000 stable and out_valid held all 5 cycles; new in_valid pulses during the wait are ignored (in_ready=0); completes on out_ready.
- Start a=9, b=0xFF, assert rst low mid-BUSY asynchronously (between edges) → out_valid=0, product=0, in_ready=1 immediately. After release, a=2, b=2 → product=4, L=2.
- Back-to-back: hold in_valid high with changing operands across two transactions → exactly two accepts, in IDLE only; products match the operands sampled at each accept edge.
